// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I issue stage: opcodes, funct fields, ALU selects
// and the packed output-register layout.
package rv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] ALU2_SLL  = 2'd0;
    localparam logic [1:0] ALU2_SLT  = 2'd1;
    localparam logic [1:0] ALU2_SR   = 2'd2;
    localparam logic [1:0] ALU2_PASS = 2'd3;

    localparam logic RES_D  = 1'b0;
    localparam logic RES_D2 = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] a2;
        logic [XLEN-1:0] b2;
        logic [1:0]      alu_op;
        logic [1:0]      alu2_op;
        logic            alt_op;
        logic            alt2_op;
        logic            res_sel;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } issue_t;
endpackage

// File: rtl/rv_operand_bypass.sv
// Resolves one source operand: x0 reads zero, then execute bypass, then
// writeback bypass, then the register file.
module rv_operand_bypass
    import rv_pkg::*;
(
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);
    always_comb begin
        if (rs == 5'd0)                      data = '0;
        else if (fwd_valid && fwd_rd == rs)  data = fwd_data;
        else if (wb_valid && wb_rd == rs)    data = wb_data;
        else                                 data = rf_data;
    end
endmodule

// File: rtl/rv_issue.sv
// RV32I decode/issue: decodes OP/OP-IMM/LUI/AUIPC into the two ALU operand
// pairs and registers them behind a valid/ready output stage.
module rv_issue
    import rv_pkg::*;
#(
    parameter int XLEN_P = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN_P-1:0] pc,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN_P-1:0] rs1_data,
    input  logic [XLEN_P-1:0] rs2_data,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_rd,
    input  logic [XLEN_P-1:0] fwd_data,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN_P-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN_P-1:0] a,
    output logic [XLEN_P-1:0] b,
    output logic [XLEN_P-1:0] a2,
    output logic [XLEN_P-1:0] b2,
    output logic [1:0]        alu_op,
    output logic [1:0]        alu2_op,
    output logic              alt_op,
    output logic              alt2_op,
    output logic              res_sel,
    output logic [4:0]        rd,
    output logic              rd_we,
    output logic              illegal
);
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1_v, rs2_v, imm_i, imm_u, opnd;
    logic            is_op, is_shift, d2_grp, bad;
    issue_t          nxt, q;

    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_u    = {inst[31:12], 12'b0};

    rv_operand_bypass u_byp1 (
        .rs(rs1_addr), .rf_data(rs1_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .data(rs1_v)
    );
    rv_operand_bypass u_byp2 (
        .rs(rs2_addr), .rf_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .data(rs2_v)
    );

    assign is_op    = (opcode == OPC_OP);
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
    assign d2_grp   = is_shift || (f3 == F3_SLT) || (f3 == F3_SLTU);
    assign opnd     = is_op ? rs2_v : (is_shift ? {27'b0, inst[24:20]} : imm_i);

    always_comb begin
        nxt = '0;
        bad = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                // funct7 is only meaningful for register ops and shift immediates
                if (is_op || is_shift)
                    bad = !((f7 == F7_BASE) ||
                            (f7 == F7_ALT && (f3 == F3_SR || (is_op && f3 == F3_ADD))));
                if (d2_grp) begin
                    nxt.a2      = rs1_v;
                    nxt.b2      = opnd;
                    nxt.res_sel = RES_D2;
                    nxt.alu2_op = (f3 == F3_SLL) ? ALU2_SLL : (f3 == F3_SR) ? ALU2_SR : ALU2_SLT;
                    nxt.alt2_op = (f3 == F3_SLT) || (f3 == F3_SR && f7[5]);
                end else begin
                    nxt.a       = rs1_v;
                    nxt.b       = opnd;
                    nxt.res_sel = RES_D;
                    nxt.alt_op  = is_op && f3 == F3_ADD && f7[5];
                    case (f3)
                        F3_AND:  nxt.alu_op = ALU_AND;
                        F3_XOR:  nxt.alu_op = ALU_XOR;
                        F3_OR:   nxt.alu_op = ALU_OR;
                        default: nxt.alu_op = ALU_ADD;
                    endcase
                end
            end
            OPC_LUI: begin
                nxt.b2      = imm_u;
                nxt.alu2_op = ALU2_PASS;
                nxt.res_sel = RES_D2;
            end
            OPC_AUIPC: begin
                nxt.a       = pc;
                nxt.b       = imm_u;
                nxt.alu_op  = ALU_ADD;
                nxt.res_sel = RES_D;
            end
            default: bad = 1'b1;
        endcase
        nxt.rd    = inst[11:7];
        nxt.rd_we = (inst[11:7] != 5'd0);
        if (bad) begin
            nxt         = '0;
            nxt.illegal = 1'b1;
        end
    end

    assign inst_ready = !ex_valid || ex_ready || flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            q        <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (inst_valid && inst_ready) begin
            ex_valid <= 1'b1;
            q        <= nxt;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign a       = q.a;
    assign b       = q.b;
    assign a2      = q.a2;
    assign b2      = q.b2;
    assign alu_op  = q.alu_op;
    assign alu2_op = q.alu2_op;
    assign alt_op  = q.alt_op;
    assign alt2_op = q.alt2_op;
    assign res_sel = q.res_sel;
    assign rd      = q.rd;
    assign rd_we   = q.rd_we;
    assign illegal = q.illegal;
endmodule

// File: tb/tb_rv_issue.sv
// Scoreboard bench for rv_issue: directed instructions push expected outputs,
// a negedge monitor pops and compares on each downstream transfer.
module tb_rv_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, inst_ready, flush, ex_valid, ex_ready;
    logic [31:0] inst, pc, rs1_data, rs2_data, fwd_data, wb_data;
    logic [4:0]  rs1_addr, rs2_addr, fwd_rd, wb_rd, rd;
    logic        fwd_valid, wb_valid;
    logic [31:0] a, b, a2, b2;
    logic [1:0]  alu_op, alu2_op;
    logic        alt_op, alt2_op, res_sel, rd_we, illegal;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a, b, a2, b2;
        logic [1:0]  ao, a2o;
        logic        alt, alt2, rs;
        logic [4:0]  rd;
        logic        we, ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rv_issue dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .a(a), .b(b), .a2(a2), .b2(b2), .alu_op(alu_op), .alu2_op(alu2_op),
        .alt_op(alt_op), .alt2_op(alt2_op), .res_sel(res_sel),
        .rd(rd), .rd_we(rd_we), .illegal(illegal)
    );

    function automatic exp_t mk(input logic [31:0] ea, eb, ea2, eb2,
                                input logic [1:0] ao, a2o,
                                input logic alt, alt2, rs,
                                input logic [4:0] erd, input logic we, ill);
        exp_t e;
        e.a = ea; e.b = eb; e.a2 = ea2; e.b2 = eb2; e.ao = ao; e.a2o = a2o;
        e.alt = alt; e.alt2 = alt2; e.rs = rs; e.rd = erd; e.we = we; e.ill = ill;
        return e;
    endfunction

    function automatic bit fld(input string n, input logic [31:0] act, input logic [31:0] ex);
        if (act !== ex) begin
            $display("FAIL %s: got %h want %h", n, act, ex);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   bad;
        if (rst_n && ex_valid) begin
            if (flush) begin
                if (sb.size() != 0) e = sb.pop_front();
            end else if (ex_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got ex_valid=1 want no transfer");
                end else begin
                    e   = sb.pop_front();
                    bad = 1'b0;
                    bad |= fld("illegal", {31'b0, illegal}, {31'b0, e.ill});
                    bad |= fld("rd_we",   {31'b0, rd_we},   {31'b0, e.we});
                    bad |= fld("alu_op",  {30'b0, alu_op},  {30'b0, e.ao});
                    bad |= fld("alu2_op", {30'b0, alu2_op}, {30'b0, e.a2o});
                    bad |= fld("alt_op",  {31'b0, alt_op},  {31'b0, e.alt});
                    bad |= fld("alt2_op", {31'b0, alt2_op}, {31'b0, e.alt2});
                    bad |= fld("res_sel", {31'b0, res_sel}, {31'b0, e.rs});
                    if (!e.ill) begin
                        bad |= fld("a",  a,  e.a);
                        bad |= fld("b",  b,  e.b);
                        bad |= fld("a2", a2, e.a2);
                        bad |= fld("b2", b2, e.b2);
                        bad |= fld("rd", {27'b0, rd}, {27'b0, e.rd});
                    end
                    if (bad) fails++;
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] ex);
        tests++;
        if (fld(n, act, ex)) fails++;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input exp_t e);
        bit rdy = 1'b0;
        inst = i; pc = p; inst_valid = 1'b1;
        #1;
        check("rs1_addr", {27'b0, rs1_addr}, {27'b0, i[19:15]});
        check("rs2_addr", {27'b0, rs2_addr}, {27'b0, i[24:20]});
        for (int n = 0; n < 20 && !rdy; n++) begin
            @(negedge clk);
            rdy = inst_ready;
            @(posedge clk);
        end
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got inst_ready=0 want 1 within 20 cycles");
        end else if (!flush) begin
            sb.push_back(e);
        end
        #1;
        inst_valid = 1'b0; fwd_valid = 1'b0; wb_valid = 1'b0;
    endtask

    localparam exp_t ILL = '{a:0, b:0, a2:0, b2:0, ao:0, a2o:0, alt:0, alt2:0, rs:0, rd:0, we:0, ill:1};

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("reset_outputs", a | b | a2 | b2 | {20'b0, alu_op, alu2_op, alt_op, alt2_op,
              res_sel, rd, rd_we, illegal}, 32'd0);
        check("reset_inst_ready", {31'b0, inst_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI x1,x0,-5 : x0 reads as zero regardless of regfile data
        rs1_data = 32'h1234;
        send(32'hFFB00093, 32'h0, mk(0, 32'hFFFFFFFB, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        // SRAI x2,x1,3 with execute bypass
        fwd_valid = 1; fwd_rd = 1; fwd_data = 32'h80000000; rs1_data = 32'h1;
        send(32'h4030D113, 32'h0, mk(0, 0, 32'h80000000, 3, 0, 2, 0, 1, 1, 2, 1, 0));
        // SUB x3,x1,x2 with writeback bypass on rs2
        rs1_data = 32'hA; rs2_data = 32'h3; wb_valid = 1; wb_rd = 2; wb_data = 32'h7;
        send(32'h402081B3, 32'h0, mk(32'hA, 32'h7, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0));
        // ADD x6,x5,x0 : fwd beats wb on the same register
        fwd_valid = 1; fwd_rd = 5; fwd_data = 32'hAAAA; wb_valid = 1; wb_rd = 5; wb_data = 32'hBBBB;
        rs1_data = 32'h1111; rs2_data = 32'h2222;
        send(32'h00028333, 32'h0, mk(32'hAAAA, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0));
        // OR x8,x0,x9 : fwd to x0 ignored, wb to x9 taken
        fwd_valid = 1; fwd_rd = 0; fwd_data = 32'hDEAD; wb_valid = 1; wb_rd = 9; wb_data = 32'h55;
        rs1_data = 32'h77; rs2_data = 32'h99;
        send(32'h00906433, 32'h0, mk(0, 32'h55, 0, 0, 3, 0, 0, 0, 0, 8, 1, 0));
        // LUI x3,0x12345
        send(32'h123451B7, 32'h0, mk(0, 0, 0, 32'h12345000, 0, 3, 0, 0, 1, 3, 1, 0));
        // AUIPC x4,1 at pc 0x100
        send(32'h00001217, 32'h100, mk(32'h100, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0));
        // SLTIU x5,x1,-1
        rs1_data = 32'h4;
        send(32'hFFF0B293, 32'h0, mk(0, 0, 32'h4, 32'hFFFFFFFF, 0, 1, 0, 0, 1, 5, 1, 0));
        // illegal: unknown opcode, bad funct7 on OP, SLLI with funct7 0100000
        send(32'h0000007F, 32'h0, ILL);
        send(32'h02208133, 32'h0, ILL);
        send(32'h40109093, 32'h0, ILL);
        repeat (2) @(posedge clk); #1;

        // Stall then flush: XORI x1,x2,0xF0 held while ex_ready=0
        ex_ready = 1'b0; rs1_data = 32'h3C;
        send(32'h0F014093, 32'h0, mk(32'h3C, 32'hF0, 0, 0, 2, 0, 0, 0, 0, 1, 1, 0));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("stall_inst_ready", {31'b0, inst_ready}, 32'd0);
            check("stall_hold", {a, b, {30'b0, alu_op}, {31'b0, ex_valid}} == {32'h3C, 32'hF0, 32'd2, 32'd1} ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b1; inst_valid = 1'b1; inst = 32'hFFB00093;
        @(negedge clk);
        check("flush_inst_ready", {31'b0, inst_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; inst_valid = 1'b0;
        check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        @(posedge clk); #1;
        check("flush_drop", {31'b0, ex_valid}, 32'd0);

        // Reset mid-stream while the output register is occupied
        send(32'h00001217, 32'h200, mk(32'h200, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0));
        check("pre_reset_ex_valid", {31'b0, ex_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("midreset_outputs", a | b | a2 | b2 | {20'b0, alu_op, alu2_op, alt_op, alt2_op,
              res_sel, rd, rd_we, illegal}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; ex_ready = 1'b1;

        // Traffic after reset still flows
        send(32'h123451B7, 32'h0, mk(0, 0, 0, 32'h12345000, 0, 3, 0, 0, 1, 3, 1, 0));
        repeat (3) @(posedge clk); #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
